fp_accumulator: RTL

Sequential IEEE-754 single-precision accumulator that sits directly downstream of `fp_multiplier` in the floating-point MAC unit. It consumes a stream of 32-bit products over a valid/ready handshake and sums them into an internal accumulator using a fixed-latency multi-cycle align/add/normalize datapath. When the operand marked last has been added, it presents the sum and then clears itself for the next dot product.

---
 rtl/fp_accumulator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fp_accumulator.sv
// fp_accumulator: sequential IEEE-754 single-precision accumulator with a
// four-state align/add/normalize datapath, one operand per four cycles.
module fp_accumulator #(
    parameter int GUARD_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_result,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int M = 24 + GUARD_BITS;
    localparam logic [7:0] MW = 8'(M);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d, op_q, op_d;
    logic        last_q, last_d;
    logic [M-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]  e_q, e_d;
    logic        s_q, s_d, sub_q, sub_d;
    logic        nan_q, nan_d, inf_q, inf_d, inf_s_q, inf_s_d;
    logic [M:0]  sum_q, sum_d;

    logic [7:0]   a_e, b_e, diff;
    logic [M-1:0] a_m, b_m, y_full;
    logic         a_big, a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        a_e    = acc_q[30:23];
        b_e    = op_q[30:23];
        a_m    = (a_e == 8'd0) ? '0 : M'({1'b1, acc_q[22:0]}) << GUARD_BITS;
        b_m    = (b_e == 8'd0) ? '0 : M'({1'b1, op_q[22:0]}) << GUARD_BITS;
        a_big  = (a_e > b_e) || (a_e == b_e && a_m >= b_m);
        diff   = a_big ? a_e - b_e : b_e - a_e;
        y_full = a_big ? b_m : a_m;
        a_inf  = a_e == 8'hFF;
        b_inf  = b_e == 8'hFF;
        a_nan  = a_inf && acc_q[22:0] != 23'd0;
        b_nan  = b_inf && op_q[22:0] != 23'd0;
    end

    logic [7:0]        lz;
    logic              carry;
    logic [M-1:0]      m_n;
    logic signed [9:0] e_n;
    logic [31:0]       res_n;

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        lz = MW;
        for (int i = 0; i < M; i++)
            if (sum_q[i]) lz = 8'(M - 1 - i);
        carry = sum_q[M];
        m_n   = carry ? sum_q[M:1] : sum_q[M-1:0] << lz;
        e_n   = carry ? $signed({2'b0, e_q}) + 10'sd1 : $signed({2'b0, e_q}) - $signed({2'b0, lz});
        res_n = nan_q ? 32'h7FC0_0000 :
                inf_q ? {inf_s_q, 8'hFF, 23'd0} :
                (sum_q == '0 || e_n <= 10'sd0) ? 32'd0 :
                (e_n >= 10'sd255) ? {s_q, 8'hFF, 23'd0} :
                {s_q, e_n[7:0], m_n[M-2:GUARD_BITS]};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
        e_d     = e_q;
        s_d     = s_q;
        sub_d   = sub_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        inf_s_d = inf_s_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = in_data;
                last_d  = in_last;
                state_d = ALIGN;
            end
            ALIGN: begin
                x_d     = a_big ? a_m : b_m;
                y_d     = (diff >= MW) ? '0 : y_full >> diff;
                e_d     = a_big ? a_e : b_e;
                s_d     = a_big ? acc_q[31] : op_q[31];
                sub_d   = acc_q[31] ^ op_q[31];
                nan_d   = a_nan || b_nan || (a_inf && b_inf && acc_q[31] != op_q[31]);
                inf_d   = a_inf || b_inf;
                inf_s_d = a_inf ? acc_q[31] : op_q[31];
                state_d = ADD;
            end
            ADD: begin
                sum_d   = sub_q ? {1'b0, x_q} - {1'b0, y_q} : {1'b0, x_q} + {1'b0, y_q};
                state_d = NORM;
            end
            NORM: begin
                acc_d   = res_n;
                state_d = last_q ? DONE : IDLE;
            end
            DONE: if (out_ready) begin
                acc_d   = 32'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            last_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            sub_q   <= 1'b0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            inf_s_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
            e_q     <= e_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
            inf_s_q <= inf_s_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign out_result = out_valid ? acc_q : 32'd0;
endmodule
